// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: state encoding and default operand width.
package mul_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mul_add_datapath.sv
// Multiplier datapath: multiplicand, iteration counter and accumulator, with a zero flag for the controller.
// Optional MUL_SWAP_OPERANDS_EN: iterate over the smaller operand to shorten latency.
module mul_add_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               zero
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (load) begin
`ifdef MUL_SWAP_OPERANDS_EN
      if (b_in > a_in) begin
        mcand_d = b_in;
        cnt_d   = a_in;
      end else begin
        mcand_d = a_in;
        cnt_d   = b_in;
      end
`else
      mcand_d = a_in;
      cnt_d   = b_in;
`endif
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_q + {{WIDTH{1'b0}}, mcand_q};
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign acc  = acc_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/multiplication_using_repeated_addition.sv
// Sequential unsigned multiplier by repeated addition: IDLE/RUN/DONE controller plus product register.
// Build option MUL_SWAP_OPERANDS_EN (in mul_add_datapath) iterates over min(a_in, b_in).
module multiplication_using_repeated_addition
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [2*WIDTH-1:0] acc;
  logic               zero;
  logic               load;
  logic               step;

  mul_add_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a_in (a_in),
    .b_in (b_in),
    .acc  (acc),
    .zero (zero)
  );

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (zero) begin
          product_d = acc;
          state_d   = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_multiplication_using_repeated_addition.sv
// Directed self-checking bench for multiplication_using_repeated_addition (default and MUL_SWAP_OPERANDS_EN builds).
module tb_multiplication_using_repeated_addition;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  multiplication_using_repeated_addition #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Launch one multiply, count edges (accept edge = 1) until done, then check result and pulse width.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_lat);
    int cycles;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    a_in  = 16'h1234;
    b_in  = 16'h0042;
    while (!done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, "_product"}, 64'(product), 64'(exp_p));
    @(posedge clk); #1;
    check({tag, "_done_off"}, 64'(done), 64'd0);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ndone;
    int idx[$];
    logic [31:0] pseen;
    int hold_lat;

    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifdef MUL_SWAP_OPERANDS_EN
    do_mul("t1_3x5", 16'd3, 16'd5, 32'd15, 5);
    do_mul("t2_7x0", 16'd7, 16'd0, 32'd0, 2);
    do_mul("t2_0x9", 16'd0, 16'd9, 32'd0, 2);
`else
    do_mul("t1_3x5", 16'd3, 16'd5, 32'd15, 7);
    do_mul("t2_7x0", 16'd7, 16'd0, 32'd0, 2);
    do_mul("t2_0x9", 16'd0, 16'd9, 32'd0, 11);
`endif
    do_mul("t3_ffffx3", 16'hFFFF, 16'd3, 32'h0002_FFFD, 5);
    do_mul("t3_1x1", 16'd1, 16'd1, 32'd1, 3);

    // Test 4: second start while RUN must be ignored
    @(negedge clk);
    a_in = 16'd2; b_in = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 16'd9; b_in = 16'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    pseen = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        pseen = product;
      end
    end
    check("t4_done_count", 64'(ndone), 64'd1);
    check("t4_product", 64'(pseen), 64'd8);

    // Test 5: reset mid-RUN
    @(negedge clk);
    a_in = 16'd6; b_in = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_mul("t5_4x4", 16'd4, 16'd4, 32'd16, 6);

    // Test 6: level-held start retriggers every latency+1 cycles
`ifdef MUL_SWAP_OPERANDS_EN
    hold_lat = 4;
`else
    hold_lat = 5;
`endif
    @(negedge clk);
    a_in = 16'd2; b_in = 16'd3; start = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk); #1;
      if (done) begin
        idx.push_back(i);
        check("t6_product", 64'(product), 64'd6);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("t6_pulses_ge3", 64'(idx.size() >= 3), 64'd1);
    if (idx.size() >= 3) begin
      check("t6_first", 64'(idx[0]), 64'(hold_lat));
      check("t6_period1", 64'(idx[1] - idx[0]), 64'(hold_lat + 1));
      check("t6_period2", 64'(idx[2] - idx[1]), 64'(hold_lat + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
